keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 131072: clk cycles each column is driven; legal values are >= 4.
REQ-002 The block SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive identical full sweeps needed to accept a press or a release; legal range is 2..15.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port row, input, 4 bits: keypad rows, active-low, asynchronous to clk; row[0] is the top row.
REQ-006 The block SHALL have port col, output, 4 bits: keypad column drive, active-low, exactly one bit low; col[0] is the leftmost column.
REQ-007 The block SHALL have port key_code, output, 5 bits: code of the last accepted key, in the same 5-bit digit code space used by the display driver.
REQ-008 The block SHALL have port key_valid, output, 1 bit: one-cycle pulse when a new key is accepted.
REQ-009 The block SHALL have port key_held, output, 1 bit: high while an accepted key remains pressed.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer before use; synchronizer flops SHALL reset to 4'b1111.
REQ-011 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; at terminal count the column index SHALL advance 0->1->2->3->0, with col = ~(1<<index).
REQ-012 The synchronized rows SHALL be sampled for the current column at prescaler terminal count, immediately before the column advances.
REQ-013 A sweep SHALL end at the column-3 sample; the sweep result SHALL be NONE (no key), ONE(code) (exactly one key), or MULTI (two or more keys, treated as NONE).
REQ-014 Key map (row, col) SHALL be: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: 0,F,E,D, encoded 5'h00..5'h0F.
REQ-015 The FSM SHALL have states IDLE, DEBOUNCE, HELD, RELEASE and SHALL evaluate only at sweep end.
REQ-016 In IDLE, ONE(c) SHALL cause a transition to DEBOUNCE with cand=c and cnt=1; any other result SHALL leave the FSM in IDLE.
REQ-017 In DEBOUNCE, ONE(cand) SHALL increment cnt.
REQ-018 In DEBOUNCE, when cnt reaches DEBOUNCE_SCANS the FSM SHALL go to HELD, load key_code=cand, and pulse key_valid for exactly one cycle, one clk after the sweep-end sample.
REQ-019 In DEBOUNCE, any result other than ONE(cand) SHALL return the FSM to IDLE with cnt=0 and no pulse.
REQ-020 In HELD, key_held SHALL be 1; ONE(key_code) SHALL stay in HELD, and any other result SHALL go to RELEASE with cnt=1.
REQ-021 In RELEASE, each NONE/MULTI/different-key sweep SHALL increment cnt; at DEBOUNCE_SCANS the FSM SHALL go to IDLE with key_held=0.
REQ-022 In RELEASE, ONE(key_code) SHALL return the FSM to HELD with cnt=0.
REQ-023 A different key SHALL never produce key_valid without first passing through IDLE, so one press yields one pulse.
REQ-024 key_code SHALL change only on a key_valid cycle and SHALL hold its value otherwise, including after release.
REQ-025 Row changes mid-dwell SHALL be tolerated: only the terminal-count sample SHALL count.

Reset
REQ-026 Asserting rst_n low SHALL, asynchronously: set FSM=IDLE, prescaler=0, column index=0, col=4'b1110, cnt=0, cand=0, key_code=5'h00, key_valid=0, key_held=0, and synchronizer=4'b1111.
REQ-027 Reset mid-operation SHALL abandon any debounce or held state, and no key_valid SHALL occur for a key already pressed until DEBOUNCE_SCANS full sweeps after release of reset.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3, sweep=16 clk)
REQ-028 Reset and column rotation -> col=1110 during reset; after reset col SHALL cycle 1110,1101,1011,0111, each for 4 clk, wrapping with outputs 0.
REQ-029 Holding '5' (row1 low while col[1] is low) -> exactly one key_valid with key_code=5'h05 after the 3rd qualifying sweep; key_held=1 until 3 empty sweeps after release.
REQ-030 Pressing 'D' that bounces (present/absent on alternate sweeps for 8 sweeps) -> no key_valid, key_held=0.
REQ-031 Pressing '1' and '6' simultaneously for 10 sweeps -> no key_valid; key_code remains at its prior value.
REQ-032 After '5' is accepted, releasing it for 1 sweep and then re-pressing -> stays HELD, no second pulse; after full release, pressing 'A' -> key_valid with key_code=5'h0A.
REQ-033 rst_n pulsed low while HELD on '9' with the key kept pressed -> outputs clear immediately, then one new key_valid with key_code=5'h09 after 3 sweeps.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low keypad column scanner with per-sweep debounce.
// Emits a one-cycle key_valid per accepted press and holds key_held until release.
module keypad_scanner #(
  parameter int SCAN_DIV       = 131072,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  // Entry index is row*4+col, entry 0 in the least significant 5 bits
  localparam logic [79:0] KMAP = {5'hD, 5'hE, 5'hF, 5'h0,
                                  5'hC, 5'h9, 5'h8, 5'h7,
                                  5'hB, 5'h6, 5'h5, 5'h4,
                                  5'hA, 5'h3, 5'h2, 5'h1};
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;
  state_t state_q, state_d;
  logic [3:0] sync1_q, sync2_q;
  logic [DW-1:0] div_q;
  logic [1:0] idx_q, acc_n_q, col_n, prior_n, sum_n;
  logic [2:0] tot_n;
  logic [4:0] acc_code_q, col_code, sum_code, cand_q, cand_d, key_code_q, key_code_d;
  logic [3:0] cnt_q, cnt_d;
  logic valid_q, valid_d, tc, sweep_end, one, same_cand, same_key;
  assign tc        = div_q == DW'(SCAN_DIV - 1);
  assign sweep_end = tc && idx_q == 2'd3;
  assign col       = ~(4'b0001 << idx_q);
  assign key_code  = key_code_q;
  assign key_valid = valid_q;
  assign key_held  = state_q == HELD || state_q == RELEASE;
  // Hit count saturates at 2 so any multi-key sweep reads as MULTI
  always_comb begin
    col_n = 2'd0;
    col_code = 5'h00;
    for (int r = 0; r < 4; r++) begin
      if (!sync2_q[r]) begin
        col_n = (col_n == 2'd2) ? 2'd2 : col_n + 2'd1;
        col_code = KMAP[5*(4*r+int'(idx_q)) +: 5];
      end
    end
    prior_n = (idx_q == 2'd0) ? 2'd0 : acc_n_q;
    tot_n = {1'b0, prior_n} + {1'b0, col_n};
    sum_n = (tot_n >= 3'd2) ? 2'd2 : tot_n[1:0];
    sum_code = (col_n != 2'd0) ? col_code : acc_code_q;
  end
  assign one       = sum_n == 2'd1;
  assign same_cand = one && sum_code == cand_q;
  assign same_key  = one && sum_code == key_code_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cand_d = cand_q;
    key_code_d = key_code_q;
    valid_d = 1'b0;
    if (sweep_end) begin
      case (state_q)
        IDLE: if (one) begin
          state_d = DEBOUNCE;
          cand_d = sum_code;
          cnt_d = 4'd1;
        end
        DEBOUNCE: if (same_cand) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == 4'(DEBOUNCE_SCANS)) begin
            state_d = HELD;
            key_code_d = cand_q;
            valid_d = 1'b1;
            cnt_d = 4'd0;
          end
        end else begin
          state_d = IDLE;
          cnt_d = 4'd0;
        end
        HELD: if (!same_key) begin
          state_d = RELEASE;
          cnt_d = 4'd1;
        end
        default: if (same_key) begin
          state_d = HELD;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == 4'(DEBOUNCE_SCANS)) begin
            state_d = IDLE;
            cnt_d = 4'd0;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      div_q <= '0;
      idx_q <= 2'd0;
      acc_n_q <= 2'd0;
      acc_code_q <= 5'h00;
      state_q <= IDLE;
      cnt_q <= 4'd0;
      cand_q <= 5'h00;
      key_code_q <= 5'h00;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
      div_q <= tc ? '0 : div_q + DW'(1);
      if (tc) begin
        idx_q <= idx_q + 2'd1;
        acc_n_q <= sum_n;
        acc_code_q <= sum_code;
      end
      state_q <= state_d;
      cnt_q <= cnt_d;
      cand_q <= cand_d;
      key_code_q <= key_code_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios with a key_valid scoreboard.
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] row, col;
  logic [4:0] key_code;
  logic key_valid, key_held;
  logic [15:0] pressed = 16'h0000;
  logic [4:0] exp_q[$];
  int total = 0;
  int passed = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low while its column is driven
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(pressed[4*r +: 4] & ~col);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic sweeps(input int n);
    repeat (16 * n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      chk("pulse_expected", {7'b0, key_valid}, (exp_q.size() > 0) ? 8'd1 : 8'd0);
      if (exp_q.size() > 0) chk("valid_key_code", {3'b0, key_code}, {3'b0, exp_q.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", {4'b0, col}, 8'h0E);
    chk("rst_valid", {7'b0, key_valid}, 8'd0);
    chk("rst_held", {7'b0, key_held}, 8'd0);
    chk("rst_code", {3'b0, key_code}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("col_rot_%0d", k), {4'b0, col}, {4'b0, ~(4'b0001 << ((k / 4) % 4))});
    end
    chk("idle_held", {7'b0, key_held}, 8'd0);
    chk("idle_code", {3'b0, key_code}, 8'h00);
    // Key '5' held and accepted on the third sweep
    exp_q.push_back(5'h05);
    pressed = 16'h0020;
    sweeps(2);
    chk("k5_not_yet_held", {7'b0, key_held}, 8'd0);
    chk("k5_pending", 8'(exp_q.size()), 8'd1);
    sweeps(1);
    chk("k5_held", {7'b0, key_held}, 8'd1);
    chk("k5_code", {3'b0, key_code}, 8'h05);
    sweeps(2);
    chk("k5_still_held", {7'b0, key_held}, 8'd1);
    // Brief release then re-press: stays held with no second pulse
    pressed = 16'h0000;
    sweeps(1);
    chk("k5_release1_held", {7'b0, key_held}, 8'd1);
    pressed = 16'h0020;
    sweeps(2);
    chk("k5_repress_held", {7'b0, key_held}, 8'd1);
    pressed = 16'h0000;
    sweeps(2);
    chk("k5_rel2_held", {7'b0, key_held}, 8'd1);
    sweeps(1);
    chk("k5_released", {7'b0, key_held}, 8'd0);
    chk("k5_code_kept", {3'b0, key_code}, 8'h05);
    // Key 'A' after full release
    exp_q.push_back(5'h0A);
    pressed = 16'h0008;
    sweeps(3);
    chk("kA_held", {7'b0, key_held}, 8'd1);
    chk("kA_code", {3'b0, key_code}, 8'h0A);
    pressed = 16'h0000;
    sweeps(3);
    chk("kA_released", {7'b0, key_held}, 8'd0);
    // Bouncing 'D' never qualifies
    for (int i = 0; i < 8; i++) begin
      pressed = (i % 2 == 0) ? 16'h8000 : 16'h0000;
      sweeps(1);
    end
    chk("bounce_held", {7'b0, key_held}, 8'd0);
    chk("bounce_code", {3'b0, key_code}, 8'h0A);
    pressed = 16'h0000;
    sweeps(1);
    // '1' and '6' together are MULTI
    pressed = 16'h0041;
    sweeps(10);
    chk("multi_held", {7'b0, key_held}, 8'd0);
    chk("multi_code", {3'b0, key_code}, 8'h0A);
    chk("multi_no_pulse", 8'(exp_q.size()), 8'd0);
    pressed = 16'h0000;
    sweeps(1);
    // '9' accepted, then reset mid-hold with the key still down
    exp_q.push_back(5'h09);
    pressed = 16'h0400;
    sweeps(3);
    chk("k9_held", {7'b0, key_held}, 8'd1);
    chk("k9_code", {3'b0, key_code}, 8'h09);
    sweeps(1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_held", {7'b0, key_held}, 8'd0);
    chk("arst_code", {3'b0, key_code}, 8'h00);
    chk("arst_col", {4'b0, col}, 8'h0E);
    chk("arst_valid", {7'b0, key_valid}, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("arst_col_hold", {4'b0, col}, 8'h0E);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(5'h09);
    sweeps(2);
    chk("k9r_not_yet_held", {7'b0, key_held}, 8'd0);
    chk("k9r_pending", 8'(exp_q.size()), 8'd1);
    sweeps(1);
    chk("k9r_held", {7'b0, key_held}, 8'd1);
    chk("k9r_code", {3'b0, key_code}, 8'h09);
    pressed = 16'h0000;
    sweeps(3);
    chk("k9r_released", {7'b0, key_held}, 8'd0);
    chk("pending_pulses", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
